// File: rtl/switch_pkg.sv
// Shared switch definitions: sizing, scheduler state encoding and the
// round-robin pick used by every output port arbiter.
package switch_pkg;

    localparam int NUM_PORTS     = 4;
    localparam int DATA_W        = 33;
    localparam int EOP_BIT       = DATA_W - 1;
    localparam int MAX_PKT_WORDS = 64;
    localparam int CNT_W         = 7;
    localparam int IDX_W         = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        CAPT
    } state_t;

    // First requester strictly after 'last', wrapping; the previous owner is lowest priority.
    function automatic logic [NUM_PORTS-1:0] rr_pick(
        input logic [NUM_PORTS-1:0] req,
        input logic [IDX_W-1:0]     last
    );
        logic [NUM_PORTS-1:0] gnt;
        logic [IDX_W-1:0]     idx;
        logic                 found;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            idx = IDX_W'((32'(last) + i) % NUM_PORTS);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick over the request vector, with the
// previous packet owner remembered so it becomes lowest priority next time.
module rr_arbiter (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [switch_pkg::NUM_PORTS-1:0] req,
    input  logic                             done,
    input  logic [switch_pkg::NUM_PORTS-1:0] owner,
    output logic [switch_pkg::NUM_PORTS-1:0] pick
);
    import switch_pkg::*;

    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (done) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (owner[i]) begin
                    last_grant_d = IDX_W'(i);
                end
            end
        end
        pick = rr_pick(req, last_grant_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/out_port_sched.sv
// Output port scheduler: drains the per-input queues one packet at a time in
// round-robin order and forwards words over a valid/ready link.
module out_port_sched #(
    parameter int NUM_PORTS     = switch_pkg::NUM_PORTS,
    parameter int DATA_W        = switch_pkg::DATA_W,
    parameter int MAX_PKT_WORDS = switch_pkg::MAX_PKT_WORDS,
    parameter int CNT_W         = switch_pkg::CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        q_empty,
    output logic [NUM_PORTS-1:0]        q_rd_en,
    input  logic [NUM_PORTS*DATA_W-1:0] q_rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [NUM_PORTS-1:0]        grant,
    output logic                        pkt_err
);
    import switch_pkg::*;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic                   pkt_err_q, pkt_err_d;
    logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;

    logic [DATA_W-1:0]      sel_word;
    logic                   sel_empty;
    logic                   rd_fire;
    logic [CNT_W-1:0]       cnt_inc;
    logic [NUM_PORTS-1:0]   pick;
    logic                   arb_done;

    rr_arbiter u_arb (
        .clk   (clk),
        .rst_n (rst),
        .req   (~q_empty),
        .done  (arb_done),
        .owner (grant_q),
        .pick  (pick)
    );

    always_comb begin
        sel_word  = '0;
        sel_empty = 1'b1;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                sel_word  = q_rd_data[i*DATA_W +: DATA_W];
                sel_empty = q_empty[i];
            end
        end
        // A read is only issued when the output register will be free by capture time.
        rd_fire = (state_q == REQ) && !sel_empty && (!out_valid_q || out_ready);
        q_rd_en = rd_fire ? grant_q : '0;
        cnt_inc = word_cnt_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        word_cnt_d  = word_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        pkt_err_d   = 1'b0;
        arb_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!(&q_empty)) begin
                    grant_d    = pick;
                    word_cnt_d = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (rd_fire) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                out_data_d  = sel_word;
                out_valid_d = 1'b1;
                word_cnt_d  = cnt_inc;
                if (sel_word[DATA_W-1]) begin
                    arb_done = 1'b1;
                    grant_d  = '0;
                    state_d  = IDLE;
                end else if (cnt_inc == CNT_W'(MAX_PKT_WORDS)) begin
                    pkt_err_d = 1'b1;
                    arb_done  = 1'b1;
                    grant_d   = '0;
                    state_d   = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            pkt_err_q   <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            pkt_err_q   <= pkt_err_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign grant     = grant_q;
    assign pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_out_port_sched.sv
// Bench for out_port_sched: behavioural queues with 1-cycle read latency and a
// packet-level round-robin model predicting word and grant order.
module tb_out_port_sched;

    localparam int NP = 4;
    localparam int DW = 33;
    localparam int MAXW = 64;

    logic               clk = 1'b1;
    logic               rst;
    logic [NP-1:0]      q_empty = '1;
    logic [NP-1:0]      q_rd_en;
    logic [NP*DW-1:0]   q_rd_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [DW-1:0]      out_data;
    logic [NP-1:0]      grant;
    logic               pkt_err;

    out_port_sched #(
        .NUM_PORTS     (NP),
        .DATA_W        (DW),
        .MAX_PKT_WORDS (MAXW),
        .CNT_W         (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .q_empty   (q_empty),
        .q_rd_en   (q_rd_en),
        .q_rd_data (q_rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .grant     (grant),
        .pkt_err   (pkt_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo  [NP][$];
    logic [DW-1:0] mword [NP][$];
    logic [DW-1:0] got   [$];
    logic [NP-1:0] glog  [$];
    logic [DW-1:0] exp_w [$];
    logic [NP-1:0] exp_g [$];
    logic [NP-1:0] prev_grant = '0;
    int            err_pulses = 0;
    int            tb_last = NP - 1;
    int            total = 0;
    int            bad = 0;

    // Queue model (1-cycle read latency) and output/grant monitor.
    always @(posedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (pkt_err) err_pulses++;
            if (grant != '0 && grant != prev_grant) glog.push_back(grant);
        end
        prev_grant = grant;
        for (int i = 0; i < NP; i++) begin
            if (q_rd_en[i] && fifo[i].size() > 0) q_rd_data[i*DW +: DW] <= fifo[i].pop_front();
        end
        for (int i = 0; i < NP; i++) q_empty[i] <= (fifo[i].size() == 0);
    end

    task automatic push(input int p, input logic eop, input logic [31:0] pl, input bit to_model);
        fifo[p].push_back({eop, pl});
        if (to_model) mword[p].push_back({eop, pl});
        q_empty[p] = 1'b0;
    endtask

    // Packet-level round robin: each packet ends at eop or after MAXW words.
    task automatic model_run();
        int p;
        int n;
        bit any;
        logic [DW-1:0] w;
        logic [NP-1:0] g;
        exp_w.delete();
        exp_g.delete();
        while (1) begin
            any = 0;
            p = 0;
            for (int i = 1; i <= NP; i++) begin
                p = (tb_last + i) % NP;
                if (mword[p].size() > 0) begin any = 1; break; end
            end
            if (!any) break;
            g = '0;
            g[p] = 1'b1;
            exp_g.push_back(g);
            n = 0;
            do begin
                w = mword[p].pop_front();
                exp_w.push_back(w);
                n++;
            end while (!w[DW-1] && n < MAXW && mword[p].size() > 0);
            tb_last = p;
        end
    endtask

    task automatic wait_words(input int n, input int budget, input bit rnd, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (got.size() >= n) begin ok = 1; break; end
        end
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tb_last = NP - 1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #15;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        total++; if (grant !== '0) begin bad++; $display("FAIL reset grant: got %b want 0000", grant); end
        total++; if (q_rd_en !== '0) begin bad++; $display("FAIL reset q_rd_en: got %b want 0000", q_rd_en); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset out_data: got %h want 0", out_data); end
        total++; if (pkt_err !== 1'b0) begin bad++; $display("FAIL reset pkt_err: got %b want 0", pkt_err); end
        rst = 1'b1;
        tb_last = NP - 1;
    endtask

    task automatic test_single();
        logic [NP-1:0] e_rd [3];
        logic [NP-1:0] e_g  [3];
        logic          e_v  [3];
        e_rd = '{4'b0001, 4'b0000, 4'b0000};
        e_g  = '{4'b0001, 4'b0001, 4'b0000};
        e_v  = '{1'b0, 1'b0, 1'b1};
        got.delete();
        @(negedge clk);
        push(0, 1'b1, 32'd25, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (q_rd_en !== e_rd[k]) begin bad++; $display("FAIL single rd_en cyc%0d: got %b want %b", k, q_rd_en, e_rd[k]); end
            total++; if (grant !== e_g[k]) begin bad++; $display("FAIL single grant cyc%0d: got %b want %b", k, grant, e_g[k]); end
            total++; if (out_valid !== e_v[k]) begin bad++; $display("FAIL single valid cyc%0d: got %b want %b", k, out_valid, e_v[k]); end
        end
        total++; if (out_data !== 33'h1_0000_0019) begin bad++; $display("FAIL single data: got %h want 100000019", out_data); end
        repeat (3) @(negedge clk);
        total++; if (got.size() != 1) begin bad++; $display("FAIL single count: got %0d want 1", got.size()); end
        tb_last = 0;
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] ew [3];
        logic [NP-1:0] eg [3];
        bit ok;
        ew = '{{1'b1, 32'd78}, {1'b1, 32'd738}, {1'b1, 32'd5}};
        eg = '{4'b0001, 4'b0010, 4'b1000};
        pulse_reset();
        got.delete();
        glog.delete();
        @(negedge clk);
        push(0, 1'b1, 32'd78, 0);
        push(1, 1'b1, 32'd738, 0);
        push(3, 1'b1, 32'd5, 0);
        wait_words(3, 60, 0, ok);
        total++; if (!ok || got.size() != 3 || glog.size() != 3) begin
            bad++; $display("FAIL rr count: words %0d grants %0d want 3 3", got.size(), glog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (got[i] !== ew[i]) begin bad++; $display("FAIL rr word%0d: got %h want %h", i, got[i], ew[i]); end
                total++; if (glog[i] !== eg[i]) begin bad++; $display("FAIL rr grant%0d: got %b want %b", i, glog[i], eg[i]); end
            end
        end
        tb_last = 3;
    endtask

    task automatic test_multi_word();
        logic [DW-1:0] ew [4];
        logic [NP-1:0] eg [2];
        bit ok;
        ew = '{{1'b0, 32'd1}, {1'b0, 32'd2}, {1'b1, 32'd3}, {1'b1, 32'd99}};
        eg = '{4'b0100, 4'b0010};
        got.delete();
        glog.delete();
        @(negedge clk);
        push(2, 1'b0, 32'd1, 0);
        push(2, 1'b0, 32'd2, 0);
        push(2, 1'b1, 32'd3, 0);
        ok = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (got.size() >= 1) begin ok = 1; break; end
        end
        push(1, 1'b1, 32'd99, 0);
        total++; if (!ok) begin bad++; $display("FAIL multi first word: timeout got %0d want 1", got.size()); end
        wait_words(4, 60, 0, ok);
        total++; if (!ok || got.size() != 4 || glog.size() != 2) begin
            bad++; $display("FAIL multi count: words %0d grants %0d want 4 2", got.size(), glog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (got[i] !== ew[i]) begin bad++; $display("FAIL multi word%0d: got %h want %h", i, got[i], ew[i]); end
            end
            for (int i = 0; i < 2; i++) begin
                total++; if (glog[i] !== eg[i]) begin bad++; $display("FAIL multi grant%0d: got %b want %b", i, glog[i], eg[i]); end
            end
        end
        tb_last = 1;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w0;
        logic [DW-1:0] w1;
        bit ok;
        w0 = {1'b0, 32'd11};
        w1 = {1'b1, 32'd22};
        got.delete();
        @(negedge clk);
        out_ready = 1'b0;
        push(3, 1'b0, 32'd11, 0);
        push(3, 1'b1, 32'd22, 0);
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL bp valid: timeout out_valid %b want 1", out_valid); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || out_data !== w0) begin
                bad++; $display("FAIL bp hold cyc%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, w0);
            end
            total++; if (q_rd_en !== '0) begin bad++; $display("FAIL bp rd_en cyc%0d: got %b want 0000", k, q_rd_en); end
        end
        out_ready = 1'b1;
        wait_words(2, 30, 0, ok);
        total++; if (got.size() != 2) begin
            bad++; $display("FAIL bp count: got %0d want 2", got.size());
        end else begin
            total++; if (got[0] !== w0 || got[1] !== w1) begin
                bad++; $display("FAIL bp words: got %h %h want %h %h", got[0], got[1], w0, w1);
            end
        end
        tb_last = 3;
    endtask

    task automatic test_underrun();
        logic [DW-1:0] ew [4];
        bit ok;
        ew = '{{1'b0, 32'hA1}, {1'b0, 32'hA2}, {1'b0, 32'hA3}, {1'b1, 32'hA4}};
        got.delete();
        glog.delete();
        @(negedge clk);
        push(0, 1'b0, 32'hA1, 0);
        push(0, 1'b0, 32'hA2, 0);
        wait_words(2, 30, 0, ok);
        total++; if (!ok) begin bad++; $display("FAIL underrun first: timeout got %0d want 2", got.size()); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++; if (grant !== 4'b0001 || q_rd_en !== '0) begin
                bad++; $display("FAIL underrun hold cyc%0d: got g=%b rd=%b want g=0001 rd=0000", k, grant, q_rd_en);
            end
        end
        push(0, 1'b0, 32'hA3, 0);
        push(0, 1'b1, 32'hA4, 0);
        wait_words(4, 30, 0, ok);
        total++; if (got.size() != 4 || glog.size() != 1) begin
            bad++; $display("FAIL underrun count: words %0d grants %0d want 4 1", got.size(), glog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (got[i] !== ew[i]) begin bad++; $display("FAIL underrun word%0d: got %h want %h", i, got[i], ew[i]); end
            end
        end
        tb_last = 0;
    endtask

    task automatic test_overlength();
        bit ok;
        got.delete();
        glog.delete();
        err_pulses = 0;
        @(negedge clk);
        for (int k = 0; k < MAXW; k++) push(1, 1'b0, 32'(k + 100), 1);
        push(2, 1'b1, 32'h77, 1);
        model_run();
        wait_words(exp_w.size(), 400, 0, ok);
        total++; if (err_pulses != 1) begin bad++; $display("FAIL overlen pkt_err: got %0d pulses want 1", err_pulses); end
        total++; if (got.size() != exp_w.size() || glog.size() != exp_g.size()) begin
            bad++; $display("FAIL overlen count: words %0d/%0d grants %0d/%0d", got.size(), exp_w.size(), glog.size(), exp_g.size());
        end else begin
            for (int i = 0; i < exp_w.size(); i++) begin
                total++; if (got[i] !== exp_w[i]) begin bad++; $display("FAIL overlen word%0d: got %h want %h", i, got[i], exp_w[i]); end
            end
            for (int i = 0; i < exp_g.size(); i++) begin
                total++; if (glog[i] !== exp_g[i]) begin bad++; $display("FAIL overlen grant%0d: got %b want %b", i, glog[i], exp_g[i]); end
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int npk;
        int len;
        int nw;
        for (int r = 0; r < 4; r++) begin
            got.delete();
            glog.delete();
            err_pulses = 0;
            nw = 0;
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                npk = $urandom_range(0, 2);
                for (int k = 0; k < npk; k++) begin
                    len = $urandom_range(1, 5);
                    for (int j = 0; j < len; j++) begin
                        push(p, (j == len - 1), $urandom, 1);
                        nw++;
                    end
                end
            end
            if (nw == 0) push(r % NP, 1'b1, $urandom, 1);
            model_run();
            wait_words(exp_w.size(), 40 * exp_w.size() + 50, 1, ok);
            total++; if (err_pulses != 0) begin bad++; $display("FAIL rand%0d pkt_err: got %0d want 0", r, err_pulses); end
            total++; if (got.size() != exp_w.size() || glog.size() != exp_g.size()) begin
                bad++; $display("FAIL rand%0d count: words %0d/%0d grants %0d/%0d", r, got.size(), exp_w.size(), glog.size(), exp_g.size());
            end else begin
                for (int i = 0; i < exp_w.size(); i++) begin
                    total++; if (got[i] !== exp_w[i]) begin bad++; $display("FAIL rand%0d word%0d: got %h want %h", r, i, got[i], exp_w[i]); end
                end
                for (int i = 0; i < exp_g.size(); i++) begin
                    total++; if (glog[i] !== exp_g[i]) begin bad++; $display("FAIL rand%0d grant%0d: got %b want %b", r, i, glog[i], exp_g[i]); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [DW-1:0] ew [3];
        bit ok;
        ew = '{{1'b0, 32'h42}, {1'b0, 32'h43}, {1'b1, 32'h44}};
        got.delete();
        @(negedge clk);
        push(0, 1'b0, 32'h41, 0);
        push(0, 1'b0, 32'h42, 0);
        push(0, 1'b0, 32'h43, 0);
        push(0, 1'b1, 32'h44, 0);
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (q_rd_en[0]) begin ok = 1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL rstmid read: timeout rd_en %b want 0001", q_rd_en); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || grant !== '0 || q_rd_en !== '0) begin
            bad++; $display("FAIL rstmid async: got v=%b g=%b rd=%b want 0 0000 0000", out_valid, grant, q_rd_en);
        end
        @(negedge clk);
        rst = 1'b1;
        tb_last = NP - 1;
        glog.delete();
        got.delete();
        wait_words(3, 40, 0, ok);
        total++; if (got.size() != 3 || glog.size() != 1) begin
            bad++; $display("FAIL rstmid count: words %0d grants %0d want 3 1", got.size(), glog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (got[i] !== ew[i]) begin bad++; $display("FAIL rstmid word%0d: got %h want %h", i, got[i], ew[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_multi_word();
        test_backpressure();
        test_underrun();
        test_overlength();
        test_random();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/out_port_sched.md
Name: out_port_sched

Overview:
- Read side of the switch's per-input queues: one instance per output port.
- Drains up to NUM_PORTS input queues with round-robin arbitration, one packet at a time.
- Forwards the words to the output link over a valid/ready handshake.
- Pairs with the queue block: the queue is written by the ingress logic; this block issues its rd_en and consumes its rd_data.

Parameters:
- NUM_PORTS, 4, number of input queues arbitrated.
- DATA_W, 33, queue word width; bit DATA_W-1 = end-of-packet (eop), bits DATA_W-2:0 = payload.
- MAX_PKT_WORDS, 64, packet length limit before forced release.
- CNT_W, 7, width of the packet word counter; must satisfy 2^CNT_W > MAX_PKT_WORDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- q_empty  in  NUM_PORTS  per-queue empty flag; bit i for queue i.
- q_rd_en  out  NUM_PORTS  per-queue read strobe; at most one bit high.
- q_rd_data  in  NUM_PORTS*DATA_W  flattened queue read data; queue i at slice [i*DATA_W +: DATA_W].
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  downstream accepts the word this cycle.
- out_data  out  DATA_W  forwarded word, eop bit preserved.
- grant  out  NUM_PORTS  one-hot owner of the current packet; 0 when idle.
- pkt_err  out  1  one-cycle pulse when a packet is force-released at MAX_PKT_WORDS.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, grant=0, q_rd_en=0, out_valid=0, out_data=0, pkt_err=0, word_cnt=0, last_grant=NUM_PORTS-1 (queue 0 wins first).
- Queue read latency is fixed at 1 cycle: rd_data is valid the cycle after rd_en is sampled high.
- q_rd_en is combinational from state; all other outputs are registered.
- FSM states: IDLE, REQ, CAPT.
- IDLE:
  - If any q_empty bit is 0, grant the first non-empty queue searching upward from last_grant+1 (mod NUM_PORTS).
  - Clear word_cnt and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - Issue read when !q_empty[g] && (!out_valid || out_ready): q_rd_en[g]=1 for exactly this cycle, then go to CAPT.
  - If q_empty[g]=1 (mid-packet underrun), hold the grant and stay in REQ; never switch queue mid-packet.
- CAPT:
  - Load the word into out_data and set out_valid; word_cnt++.
  - If eop=1: last_grant<=g, grant<=0, go to IDLE.
  - Else if word_cnt+1 == MAX_PKT_WORDS: pulse pkt_err, last_grant<=g, grant<=0, go to IDLE.
  - Else go to REQ.
- Output register:
  - out_valid clears on out_valid&&out_ready unless reloaded in the same cycle (CAPT).
  - out_data is stable while out_valid && !out_ready.
- Throughput: at most one read in flight; peak rate is 1 word / 2 cycles.
- At most one outstanding word in the output register, so no overflow is possible.
- Simultaneous requests: strict round-robin; a queue that just finished is lowest priority next arbitration.
- Single-word packet (eop on first word): IDLE->REQ->CAPT->IDLE, 3 cycles.
- Asynchronous reset mid-packet: everything returns to reset values. The partially read packet is abandoned; its remaining words are treated as a new packet later.

Decomposition:
- Shared package switch_pkg holds:
  - localparams NUM_PORTS, DATA_W, EOP_BIT = DATA_W-1.
  - state encoding IDLE/REQ/CAPT.
  - function rr_pick(req, last) returning a one-hot grant.
- Natural sub-module: rr_arbiter (combinational pick plus registered last_grant), reused by other output ports.

Test Plan:
- Reset and single-word packet:
  - Stimulus: reset with rst=0 for 15 time units; queue 0 holds one word 33'h1_0000_0019 (eop=1, payload 25).
  - Required: q_rd_en=4'b0001 for exactly 1 cycle; out_data=33'h1_0000_0019 with out_valid=1 one cycle later; grant returns to 0.
- Round-robin:
  - Stimulus: queues 0, 1 and 3 each hold one 1-word packet, with payloads 78, 738 and 5.
  - Required: grant sequence 0001 -> 0010 -> 1000; output payload order 78, 738, 5.
- Multi-word packet with an empty queue elsewhere:
  - Stimulus: queue 2 holds 3 words, payloads 1, 2, 3, with eop on the last; queue 1 becomes non-empty mid-packet.
  - Required: all three words are output before queue 1 gets grant.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles during a 2-word packet.
  - Required: out_data is held stable; q_rd_en stays 0 while the register is full; no word is lost or duplicated.
- Underrun and overlength:
  - Stimulus (underrun): q_empty[0] rises mid-packet.
  - Required: grant held and no reads issued; the packet resumes when data arrives.
  - Stimulus (overlength): a 64-word packet with no eop.
  - Required: pkt_err pulses once, and the next arbitration occurs.
- Reset mid-packet:
  - Stimulus: assert rst during CAPT.
  - Required: out_valid=0, grant=0 and q_rd_en=0 immediately (asynchronous reset, no clock edge needed).
